// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers.
// Used by the SRAM slave as well as by fabric and master models.
package ahb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  // Replace the byte lanes selected by strobe, keep the rest of old_word.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [LANES-1:0]  strobe);
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < int'(LANES); i++) begin
      if (strobe[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane strobe and alignment check for an AHB transfer.
// Sizes above word produce an empty strobe; the caller flags them separately.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0]       size,
  input  logic [1:0]       addr_lo,
  output logic [LANES-1:0] strobe_c,
  output logic             misalign_c
);

  always_comb begin
    strobe_c   = '0;
    misalign_c = 1'b0;
    case (size)
      HSIZE_BYTE: strobe_c = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strobe_c   = 4'b0011 << addr_lo;
        misalign_c = addr_lo[0];
      end
      HSIZE_WORD: begin
        strobe_c   = 4'b1111;
        misalign_c = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave terminating transfers into a word-organised on-chip SRAM,
// with programmable wait states, byte/half/word lanes and two-cycle ERROR.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter  int unsigned DEPTH       = 256,
  parameter  int unsigned WAIT_STATES = 0,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        sHSEL,
  input  logic [31:0] sHADDR,
  input  logic [1:0]  sHTRANS,
  input  logic        sHWRITE,
  input  logic [2:0]  sHSIZE,
  input  logic [2:0]  sHBURST,
  input  logic [31:0] sHWDATA,
  input  logic        sHREADYin,
  output logic [31:0] sHRDATA,
  output logic        sHREADY,
  output logic [1:0]  sHRESP
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [AW-1:0]     word_q, word_d;
  logic              write_q, write_d;
  logic [LANES-1:0]  strobe_q, strobe_d;
  logic              ready_q, ready_d;
  hresp_t            resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [LANES-1:0]  strobe_c;
  logic              misalign_c;
  logic              accept_c;
  logic              addr_err_c;
  logic              commit_c;
  logic [DATA_W-1:0] mem_word_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{sHBURST, sHTRANS[0]};

  ahb_byte_strobe u_strobe (
    .size       (sHSIZE),
    .addr_lo    (sHADDR[1:0]),
    .strobe_c   (strobe_c),
    .misalign_c (misalign_c)
  );

  // Address phases are only seen while this slave is not stalling the bus.
  assign accept_c   = sHSEL && sHREADYin && sHTRANS[1] &&
                      ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));
  assign addr_err_c = (sHSIZE > 3'd2) || misalign_c || ((sHADDR >> (AW + 2)) != 32'd0);
  assign commit_c   = (state_q == ST_DATA) && write_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    word_d   = word_q;
    write_d  = write_q;
    strobe_d = strobe_q;
    if (accept_c) begin
      word_d   = sHADDR[AW+1:2];
      write_d  = sHWRITE && !addr_err_c;
      strobe_d = strobe_c;
    end
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 3'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept_c) begin
          state_d = ST_IDLE;
        end else if (addr_err_c) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          wcnt_d  = WAIT_INIT;
        end else begin
          state_d = ST_DATA;
        end
      end
    endcase
    ready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    resp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Read word forwarded from a write committing on the same edge.
  always_comb begin
    mem_word_c = mem[word_d];
    if (commit_c && (word_q == word_d)) mem_word_c = merge_lanes(mem[word_d], sHWDATA, strobe_q);
    rdata_d = ((state_d == ST_DATA) && !write_d) ? mem_word_c : '0;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= 3'd0;
      word_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      word_q   <= word_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  // SRAM contents survive reset; reset only abandons an uncommitted write.
  always_ff @(posedge HCLK) begin
    if (commit_c) mem[word_q] <= merge_lanes(mem[word_q], sHWDATA, strobe_q);
  end

  assign sHRDATA = rdata_q;
  assign sHREADY = ready_q;
  assign sHRESP  = resp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with zero and one with
// three wait states, driven by an AHB master model against a reference memory.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  int          active = 0;

  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3;
  logic [1:0]  resp0, resp3;
  logic        hready_bus;
  logic [1:0]  resp_a;
  logic [31:0] rdata_a;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [31:0] model [2][DEPTH];

  bit   busy = 1'b0;
  exp_t cur;
  int   waits = 0;

  assign hready_bus = (active == 1) ? rdy3 : rdy0;
  assign resp_a     = (active == 1) ? resp3 : resp0;
  assign rdata_a    = (active == 1) ? rdata3 : rdata0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset_n), .sHSEL(hsel && (active == 0)), .sHADDR(haddr),
    .sHTRANS(htrans), .sHWRITE(hwrite), .sHSIZE(hsize), .sHBURST(hburst),
    .sHWDATA(hwdata), .sHREADYin(hready_bus), .sHRDATA(rdata0), .sHREADY(rdy0),
    .sHRESP(resp0)
  );

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(hreset_n), .sHSEL(hsel && (active == 1)), .sHADDR(haddr),
    .sHTRANS(htrans), .sHWRITE(hwrite), .sHSIZE(hsize), .sHBURST(hburst),
    .sHWDATA(hwdata), .sHREADYin(hready_bus), .sHRDATA(rdata3), .sHREADY(rdy3),
    .sHRESP(resp3)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
    if (a >= 32'(DEPTH * 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                                      input logic [31:0] wd);
    int nb;
    int base;
    int w;
    nb   = 1 << s;
    base = int'(a[1:0]);
    w    = int'(a >> 2);
    for (int b = 0; b < nb; b++) model[d][w][(base + b) * 8 +: 8] = wd[(base + b) * 8 +: 8];
  endfunction

  // Issue one transfer; returns just after its address phase was accepted.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                      input bit fx = 1'b0, input logic [31:0] fexp = 32'd0);
    exp_t e;
    int   n;
    e.err   = model_err(a, s);
    e.rd    = !wr;
    e.waits = e.err ? 1 : ((active == 1) ? 3 : 0);
    e.data  = 32'd0;
    if (!e.err) begin
      if (wr) model_write(active, a, s, wd);
      else    e.data = fx ? fexp : model[active][int'(a >> 2)];
    end
    sb.push_back(e);
    hsel   = 1'b1;
    haddr  = a;
    htrans = ($urandom_range(0, 1) == 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
    hwrite = wr;
    hsize  = s;
    hburst = 3'($urandom_range(0, 7));
    n = 0;
    @(negedge clk);
    while (!hready_bus && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: hready stuck low for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    hwdata = wr ? wd : $urandom;
  endtask

  task automatic idle_cycle(input int kind);
    hsel   = (kind != 2);
    htrans = (kind == 1) ? HTRANS_BUSY : ((kind == 2) ? HTRANS_NONSEQ : HTRANS_IDLE);
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    hsize  = 3'($urandom_range(0, 2));
    @(posedge clk);
    #1;
  endtask

  task automatic random_mix(input int count);
    logic [31:0] a;
    logic [2:0]  s;
    int          r;
    for (int i = 0; i < count; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        idle_cycle(int'($urandom_range(0, 2)));
      end else begin
        a = 32'($urandom_range(0, 63));
        s = 3'($urandom_range(0, 2));
        if (r == 2) s = 3'($urandom_range(3, 7));
        if (r == 3) a = a | 32'h400;
        xfer(1'($urandom_range(0, 1)), a, s, $urandom);
      end
    end
  endtask

  // Monitor: completes a data phase whenever the active slave drives HREADY high.
  always @(negedge clk) begin
    if (!hreset_n) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        if (!hready_bus) begin
          waits++;
          chk("wait_resp", 64'(resp_a), cur.err ? 64'd1 : 64'd0);
          chk("wait_rdata", 64'(rdata_a), 64'd0);
          if (waits > 16) begin
            chk("wait_bound", 64'(waits), 64'(cur.waits));
            busy = 1'b0;
          end
        end else begin
          chk("waits", 64'(waits), 64'(cur.waits));
          chk("resp", 64'(resp_a), cur.err ? 64'd1 : 64'd0);
          if (cur.err)     chk("err_rdata", 64'(rdata_a), 64'd0);
          else if (cur.rd) chk("rdata", 64'(rdata_a), 64'(cur.data));
          busy = 1'b0;
        end
      end else begin
        chk("idle_out", 64'({hready_bus, resp_a, rdata_a}), 64'({1'b1, 2'b00, 32'd0}));
      end
      if (hready_bus && hsel && htrans[1]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: address phase with no expected entry (t=%0t)", $time);
        end else begin
          cur   = sb.pop_front();
          busy  = 1'b1;
          waits = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", 64'(rdy0), 64'd1);
    chk("rst_resp0", 64'(resp0), 64'd0);
    chk("rst_rdata0", 64'(rdata0), 64'd0);
    chk("rst_ready3", 64'(rdy3), 64'd1);
    chk("rst_resp3", 64'(resp3), 64'd0);
    chk("rst_rdata3", 64'(rdata3), 64'd0);
    hreset_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait slave
    active = 0;
    for (int w = 0; w < 16; w++) xfer(1'b1, 32'(w * 4), 3'd2, $urandom);
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 1'b1, 32'hDEADBEEF);
    xfer(1'b1, 32'h20, 3'd2, 32'h0000_0000);
    xfer(1'b1, 32'h22, 3'd0, 32'h11AB_2233);
    xfer(1'b1, 32'h20, 3'd1, 32'h9988_1234);
    xfer(1'b0, 32'h20, 3'd2, 32'd0, 1'b1, 32'h00AB_1234);
    xfer(1'b1, 32'h02, 3'd2, 32'hCAFE_F00D);
    xfer(1'b1, 32'h400, 3'd2, 32'h0BAD_0BAD);
    xfer(1'b1, 32'h00, 3'd3, 32'h5555_AAAA);
    idle_cycle(0);
    idle_cycle(1);
    idle_cycle(2);
    xfer(1'b0, 32'h00, 3'd2, 32'd0);
    idle_cycle(1);
    xfer(1'b0, 32'h20, 3'd2, 32'd0, 1'b1, 32'h00AB_1234);
    idle_cycle(2);
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 1'b1, 32'hDEADBEEF);
    random_mix(250);
    repeat (5) idle_cycle(0);

    // Three-wait slave
    active = 1;
    for (int w = 0; w < 16; w++) xfer(1'b1, 32'(w * 4), 3'd2, $urandom);
    repeat (5) idle_cycle(0);
    xfer(1'b0, 32'h10, 3'd2, 32'd0);
    repeat (5) idle_cycle(0);
    xfer(1'b1, 32'h04, 3'd2, 32'h0BAD_F00D);
    xfer(1'b0, 32'h07, 3'd1, 32'd0);
    xfer(1'b0, 32'h04, 3'd2, 32'd0, 1'b1, 32'h0BAD_F00D);
    random_mix(150);
    repeat (6) idle_cycle(0);

    // Write to word 5 abandoned by reset while still in wait states
    begin
      exp_t e;
      e.err = 1'b0; e.rd = 1'b0; e.data = 32'd0; e.waits = 3;
      sb.push_back(e);
      hsel = 1'b1; haddr = 32'h14; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk);
      #1;
      hwdata = ~model[1][5];
      idle_cycle(0);
      #2;
      chk("pre_reset_wait", 64'(rdy3), 64'd0);
      hreset_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(rdy3), 64'd1);
      chk("mid_rst_resp", 64'(resp3), 64'd0);
      chk("mid_rst_rdata", 64'(rdata3), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      hreset_n = 1'b1;
    end
    idle_cycle(0);
    xfer(1'b0, 32'h14, 3'd2, 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'd0);
    repeat (6) idle_cycle(0);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
